// File: rtl/mesh_term_arbiter.sv
// mesh_term_arbiter
//   Shares one mesh terminal input port among N_REQ show-ahead source FIFOs.
//   A round-robin arbiter picks a pending source; the winning packet is
//   captured in a one-entry output register and held until the router pops it.
//   Packets pass through unmodified.
//
// Ports
//   clk            clock, all logic on posedge
//   reset          asynchronous, active-low reset
//   req_pndng      per-source "packet at FIFO head"
//   req_data       per-source head packet, source i at [i*pckg_sz +: pckg_sz]
//   req_pop        one-hot pop to the granted source (combinational)
//   pndng_i_in     output register holds a valid packet
//   data_out_i_in  packet presented to the router
//   term_pop       router consumes the presented packet
//   err_pop_empty  sticky flag: term_pop seen while the output was empty
//   grant_cnt      per-source saturating grant counters (ARB_STATS_EN only)
//
// Configuration
//   ARB_STATS_EN   define to add the CNT_W parameter, the grant_cnt port and
//                  the grant counters. Arbitration is identical either way.

module mesh_term_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned pckg_sz = 40
`ifdef ARB_STATS_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_pndng,
    input  logic [N_REQ*pckg_sz-1:0] req_data,
    output logic [N_REQ-1:0]         req_pop,
    output logic                     pndng_i_in,
    output logic [pckg_sz-1:0]       data_out_i_in,
    input  logic                     term_pop,
    output logic                     err_pop_empty
`ifdef ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]   grant_cnt
`endif
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W:0]     scan_idx;
    logic               found;
    logic               load;
    logic [pckg_sz-1:0] data_d;
    logic               err_d;

    // Round-robin search: first pending source at or after rr_ptr, wrapping.
    // scan_idx is one bit wider so rr_ptr + k cannot overflow before the wrap.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
            end
            if (!found && req_pndng[scan_idx[PTR_W-1:0]]) begin
                grant = scan_idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

    // Next state, load decision and combinational pop.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        data_d   = data_out_i_in;
        err_d    = err_pop_empty;
        req_pop  = '0;

        // reset gates load so no source is popped while reset is asserted
        load = ((state_q == S_EMPTY) || term_pop) && found && reset;

        if (term_pop && (state_q == S_EMPTY)) begin
            err_d = 1'b1;
        end

        if (load) begin
            req_pop  = N_REQ'(1) << grant;
            state_d  = S_FULL;
            data_d   = req_data[32'(grant)*pckg_sz +: pckg_sz];
            rr_ptr_d = (grant == PTR_W'(N_REQ-1)) ? '0 : grant + PTR_W'(1);
        end else if (term_pop) begin
            state_d = S_EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output packet register, pointer and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out_i_in <= '0;
            rr_ptr_q      <= '0;
            err_pop_empty <= 1'b0;
        end else begin
            data_out_i_in <= data_d;
            rr_ptr_q      <= rr_ptr_d;
            err_pop_empty <= err_d;
        end
    end

    assign pndng_i_in = (state_q == S_FULL);

`ifdef ARB_STATS_EN
    // Saturating per-source grant counters.
    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= '0;
            end else if (req_pop[i] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end

        assign grant_cnt[i*CNT_W +: CNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_mesh_term_arbiter.sv
// Randomized and directed bench for mesh_term_arbiter. Source FIFOs are bench
// queues; a queue-based model tracks the held packet, pointer and counters.
module tb_mesh_term_arbiter;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned PW    = 40;
`ifdef ARB_STATS_EN
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;
`endif

    logic                  clk;
    logic                  reset;
    logic [N_REQ-1:0]      req_pndng;
    logic [N_REQ*PW-1:0]   req_data;
    logic [N_REQ-1:0]      req_pop;
    logic                  pndng_i_in;
    logic [PW-1:0]         data_out_i_in;
    logic                  term_pop;
    logic                  err_pop_empty;
`ifdef ARB_STATS_EN
    logic [N_REQ*CNT_W-1:0] grant_cnt;
`endif

    mesh_term_arbiter #(
        .N_REQ   (N_REQ),
        .pckg_sz (PW)
`ifdef ARB_STATS_EN
        ,
        .CNT_W   (CNT_W)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_pndng     (req_pndng),
        .req_data      (req_data),
        .req_pop       (req_pop),
        .pndng_i_in    (pndng_i_in),
        .data_out_i_in (data_out_i_in),
        .term_pop      (term_pop),
        .err_pop_empty (err_pop_empty)
`ifdef ARB_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // source FIFOs and model state
    logic [PW-1:0] q [N_REQ][$];
    logic          m_valid;
    logic [PW-1:0] m_data;
    logic          m_err;
    int            m_ptr;
    int            m_cnt [N_REQ];
    int            glog [$];
    logic [PW-1:0] clog [$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pkt(input int src, input int idx);
        return {8'(src), 8'(idx), 24'hC0FFEE};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_err   = 1'b0;
        m_ptr   = 0;
        for (int i = 0; i < N_REQ; i++) m_cnt[i] = 0;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N_REQ; i++) q[i].delete();
        glog.delete();
        clog.delete();
    endtask

    function automatic int pick();
        for (int k = 0; k < N_REQ; k++) begin
            int i;
            i = (m_ptr + k) % N_REQ;
            if (q[i].size() > 0) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N_REQ; i++) begin
            req_pndng[i] = (q[i].size() > 0);
            req_data[i*PW +: PW] = (q[i].size() > 0) ? q[i][0] : PW'({$urandom(), $urandom()});
        end
    endtask

    // One clock: drive from queues, compare against model, advance model.
    task automatic step();
        int               g;
        logic             ld;
        logic [N_REQ-1:0] ep;
        drive();
        #1;
        g  = pick();
        ld = reset && (!m_valid || term_pop) && (g >= 0);
        ep = ld ? (N_REQ'(1) << g) : '0;
        chk("req_pop", 64'(req_pop), 64'(ep));
        chk("pndng_i_in", 64'(pndng_i_in), 64'(m_valid));
        if (m_valid) chk("data_out_i_in", 64'(data_out_i_in), 64'(m_data));
        chk("err_pop_empty", 64'(err_pop_empty), 64'(m_err));
`ifdef ARB_STATS_EN
        begin
            logic [N_REQ*CNT_W-1:0] ec;
            for (int i = 0; i < N_REQ; i++) ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
            chk("grant_cnt", 64'(grant_cnt), 64'(ec));
        end
`endif
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (term_pop && m_valid) clog.push_back(m_data);
            if (term_pop && !m_valid) m_err = 1'b1;
            if (ld) begin
                m_data  = q[g].pop_front();
                m_valid = 1'b1;
                m_ptr   = (g + 1) % N_REQ;
                glog.push_back(g);
`ifdef ARB_STATS_EN
                if (m_cnt[g] < int'(CMAX)) m_cnt[g]++;
`endif
            end else if (term_pop) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b0;
        model_reset();
        repeat (cycles) step();
        reset = 1'b1;
    endtask

    initial begin
        int exp_src [8];
        reset     = 1'b0;
        term_pop  = 1'b0;
        req_pndng = '0;
        req_data  = '0;
        model_reset();
        clear_q();
        @(negedge clk);

        // reset held with every source pending: nothing popped, nothing presented
        for (int i = 0; i < N_REQ; i++) q[i].push_back(pkt(i, 0));
        for (int c = 0; c < 3; c++) begin
            drive();
            #1;
            chk("rst_req_pop", 64'(req_pop), 64'h0);
            chk("rst_pndng", 64'(pndng_i_in), 64'h0);
            chk("rst_err", 64'(err_pop_empty), 64'h0);
            chk("rst_data", 64'(data_out_i_in), 64'h0);
            step();
        end
        reset = 1'b1;

        // single source, held without router pop
        clear_q();
        do_reset(1);
        q[2].push_back(40'hA5_0000_1234);
        term_pop = 1'b0;
        drive();
        #1;
        chk("single_pop", 64'(req_pop), 64'b0100);
        step();
        for (int c = 0; c < 10; c++) begin
            chk("single_hold_valid", 64'(pndng_i_in), 64'h1);
            chk("single_hold_data", 64'(data_out_i_in), 64'hA5_0000_1234);
            step();
        end
        term_pop = 1'b1;
        step();
        term_pop = 1'b0;
        chk("single_drained", 64'(pndng_i_in), 64'h0);

        // round-robin with continuous router pop
        clear_q();
        do_reset(1);
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N_REQ; i++) q[i].push_back(pkt(i, j));
        term_pop = 1'b1;
        repeat (9) step();
        term_pop = 1'b0;
        exp_src = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk("rr_grants", 64'(glog.size()), 64'd8);
        chk("rr_consumed", 64'(clog.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < glog.size()) chk("rr_grant_order", 64'(glog[k]), 64'(exp_src[k]));
            if (k < clog.size()) chk("rr_out_order", 64'(clog[k][39:32]), 64'(exp_src[k]));
        end

        // back-to-back with drain: sources 1 and 3, two packets each
        clear_q();
        do_reset(1);
        q[1].push_back(pkt(1, 0)); q[1].push_back(pkt(1, 1));
        q[3].push_back(pkt(3, 0)); q[3].push_back(pkt(3, 1));
        term_pop = 1'b1;
        repeat (5) step();
        term_pop = 1'b0;
        chk("b2b_drained", 64'(pndng_i_in), 64'h0);
        chk("b2b_count", 64'(clog.size()), 64'd4);
        if (clog.size() == 4) begin
            chk("b2b_0", 64'(clog[0]), 64'(pkt(1, 0)));
            chk("b2b_1", 64'(clog[1]), 64'(pkt(3, 0)));
            chk("b2b_2", 64'(clog[2]), 64'(pkt(1, 1)));
            chk("b2b_3", 64'(clog[3]), 64'(pkt(3, 1)));
        end

        // illegal pop while empty
        clear_q();
        do_reset(1);
        term_pop = 1'b1;
        step();
        term_pop = 1'b0;
        chk("illegal_err", 64'(err_pop_empty), 64'h1);
        repeat (3) step();
        chk("illegal_err_sticky", 64'(err_pop_empty), 64'h1);

        // reset pulse while holding a source-0 packet
        clear_q();
        do_reset(1);
        q[0].push_back(pkt(0, 7));
        step();
        chk("mid_full", 64'(pndng_i_in), 64'h1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_async_pndng", 64'(pndng_i_in), 64'h0);
        chk("mid_async_data", 64'(data_out_i_in), 64'h0);
        q[1].push_back(pkt(1, 8));
        q[0].push_back(pkt(0, 9));
        step();
        reset = 1'b1;
        step();
        chk("mid_grant_ptr0", 64'(glog.size() > 0 ? glog[$] : -1), 64'd0);
        chk("mid_data", 64'(data_out_i_in), 64'(pkt(0, 9)));

`ifdef ARB_STATS_EN
        // grant counters saturate
        clear_q();
        do_reset(1);
        for (int j = 0; j < 20; j++) q[0].push_back(pkt(0, j));
        term_pop = 1'b1;
        repeat (22) step();
        term_pop = 1'b0;
        chk("stats_grants", 64'(glog.size()), 64'd20);
        chk("stats_sat", 64'(grant_cnt), 64'h000F);
`endif

        // randomized traffic with occasional reset
        clear_q();
        do_reset(1);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N_REQ; i++)
                if (q[i].size() < 4 && $urandom_range(0, 9) < 3)
                    q[i].push_back(PW'({$urandom(), $urandom()}));
            term_pop = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 399) == 0) begin
                term_pop = 1'b0;
                do_reset(1);
            end else begin
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
